// File: rtl/proc_datapath_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | proc_datapath_resp : datapath responder that closes the loop with the FSM |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module proc_datapath_resp #(
  parameter logic [1:0] IDLE_STATE     = 2'd0,
  parameter logic [1:0] FETCH_STATE    = 2'd1,
  parameter logic [1:0] LOAD_REG_STATE = 2'd2,
  parameter logic [1:0] ALU_STATE      = 2'd3,
  parameter int         DATA_W         = 8,
  parameter int         PROG_DEPTH     = 16,
  localparam int        PC_W           = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        current_state,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic [PC_W-1:0]   prog_last,
  input  logic              run,
  output logic              start,
  output logic              condition_code_check,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              done
);

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  logic [15:0]       mem_q [PROG_DEPTH];

  logic              start_q, start_d;
  logic              cc_q, cc_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   iaddr_q, iaddr_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [DATA_W-1:0] result_q, result_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;
  logic              done_q, done_d;

  logic [1:0]        ir_op;
  logic [1:0]        ir_rd;
  logic [1:0]        ir_rs;
  logic [DATA_W-1:0] ir_imm;
  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;
  logic              retire;
  logic              unused_rsvd;

  assign ir_op       = ir_q[15:14];
  assign ir_rd       = ir_q[13:12];
  assign ir_rs       = ir_q[11:10];
  assign ir_imm      = DATA_W'(ir_q[7:0]);
  assign unused_rsvd = ^ir_q[9:8];

  // Instruction store is deliberately left out of reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (prog_we && !start_q) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    add_w = {1'b0, opa_q} + {1'b0, opb_q};
    sub_w = {1'b0, opa_q} - {1'b0, opb_q};
    case (ir_op)
      OP_ADD: begin
        alu_out = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
      end
      OP_SUB: begin
        alu_out = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
      end
      default: begin
        alu_out = opa_q & opb_q;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    start_d  = start_q;
    cc_d     = cc_q;
    pc_d     = pc_q;
    iaddr_d  = iaddr_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rf_d     = rf_q;
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    done_d   = 1'b0;
    retire   = 1'b0;

    if (!start_q) begin
      if (run) begin
        start_d = 1'b1;
        pc_d    = '0;
      end
    end else begin
      case (current_state)
        IDLE_STATE: ;
        FETCH_STATE: begin
          ir_d    = mem_q[pc_q];
          iaddr_d = pc_q;
          pc_d    = pc_q + PC_W'(1);
          cc_d    = (mem_q[pc_q][15:14] != OP_LDI);
        end
        LOAD_REG_STATE: begin
          opa_d = rf_q[ir_rd];
          opb_d = rf_q[ir_rs];
          if (ir_op == OP_LDI) begin
            rf_d[ir_rd] = ir_imm;
            result_d    = ir_imm;
            retire      = 1'b1;
          end
        end
        ALU_STATE: begin
          // An LDI never reaches here in a well-behaved loop; guard so it cannot clobber flags.
          if (ir_op != OP_LDI) begin
            rf_d[ir_rd] = alu_out;
            result_d    = alu_out;
            zf_d        = (alu_out == '0);
            cf_d        = alu_c;
            retire      = 1'b1;
          end
        end
        default: ;
      endcase

      if (retire && (iaddr_q == prog_last)) begin
        done_d  = 1'b1;
        start_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q  <= 1'b0;
      cc_q     <= 1'b0;
      pc_q     <= '0;
      iaddr_q  <= '0;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rf_q     <= '{default: '0};
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      cc_q     <= cc_d;
      pc_q     <= pc_d;
      iaddr_q  <= iaddr_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rf_q     <= rf_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      done_q   <= done_d;
    end
  end

  assign start                = start_q;
  assign condition_code_check = cc_q;
  assign pc                   = pc_q;
  assign result               = result_q;
  assign zero_flag            = zf_q;
  assign carry_flag           = cf_q;
  assign done                 = done_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_datapath_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_proc_datapath_resp : scoreboard bench with a model of the control FSM  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_proc_datapath_resp;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_ALU   = 2'd3;

  typedef struct {
    logic       cc;
    logic [7:0] res;
    logic       zf;
    logic       cf;
    logic       dn;
    logic       st;
    logic [3:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cs;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [3:0]  prog_last;
  logic        run;
  logic        start;
  logic        cc;
  logic [3:0]  pc;
  logic [7:0]  result;
  logic        zero_flag;
  logic        carry_flag;
  logic        done;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] m_mem [16];
  logic [7:0]  m_rf  [4];
  logic        m_zf;
  logic        m_cf;
  int          n_vec;
  int          n_err;
  int          n_done;
  bit          ret_pend;

  proc_datapath_resp dut (
    .clk                  (clk),
    .rst                  (rst),
    .current_state        (cs),
    .prog_we              (prog_we),
    .prog_addr            (prog_addr),
    .prog_wdata           (prog_wdata),
    .prog_last            (prog_last),
    .run                  (run),
    .start                (start),
    .condition_code_check (cc),
    .pc                   (pc),
    .result               (result),
    .zero_flag            (zero_flag),
    .carry_flag           (carry_flag),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Companion control FSM
  always @(posedge clk or posedge rst) begin
    if (rst)         cs <= S_IDLE;
    else if (!start) cs <= S_IDLE;
    else begin
      case (cs)
        S_IDLE:  cs <= S_FETCH;
        S_FETCH: cs <= S_LOAD;
        S_LOAD:  cs <= cc ? S_ALU : S_FETCH;
        default: cs <= S_FETCH;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [1:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 2'b00, imm};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ret_pend = 1'b0;
      sb.delete();
    end else begin
      if (done) n_done++;
      if (ret_pend) begin
        ret_pend = 1'b0;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("zero_flag", zero_flag, e.zf);
          check("carry_flag", carry_flag, e.cf);
          check("done", done, e.dn);
          check("start", start, e.st);
          check("pc", pc, e.pc);
        end
      end
      if (start && cs == S_LOAD) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          check("cc_in_load", cc, sb[0].cc);
          if (!sb[0].cc) ret_pend = 1'b1;
        end
      end else if (start && cs == S_ALU) begin
        ret_pend = 1'b1;
      end
    end
  end

  task automatic wr(input int a, input logic [15:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = w;
    m_mem[a] = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic push_exp(input int last);
    exp_t        x;
    logic [15:0] w;
    logic [8:0]  t;
    logic [1:0]  rd, rs;
    for (int a = 0; a <= last; a++) begin
      w  = m_mem[a];
      rd = w[13:12];
      rs = w[11:10];
      case (w[15:14])
        2'b00: begin m_rf[rd] = w[7:0]; x.res = w[7:0]; end
        2'b01: begin t = {1'b0, m_rf[rd]} + {1'b0, m_rf[rs]}; m_cf = t[8]; end
        2'b10: begin t = {1'b0, m_rf[rd]} - {1'b0, m_rf[rs]}; m_cf = t[8]; end
        default: begin t = {1'b0, m_rf[rd] & m_rf[rs]}; m_cf = 1'b0; end
      endcase
      if (w[15:14] != 2'b00) begin
        m_rf[rd] = t[7:0];
        x.res    = t[7:0];
        m_zf     = (t[7:0] == 8'h00);
      end
      x.cc = (w[15:14] != 2'b00);
      x.zf = m_zf;
      x.cf = m_cf;
      x.dn = (a == last);
      x.st = (a != last);
      x.pc = 4'(a + 1);
      sb.push_back(x);
    end
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic run_chk(input int last);
    bit ok;
    ok        = 1'b0;
    prog_last = 4'(last);
    push_exp(last);
    n_done = 0;
    pulse_run();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      if (!start && sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("run_timeout", 0, 1);
    @(negedge clk);
    check("done_count", n_done, 1);
  endtask

  task automatic load_add_prog();
    wr(0, ins(2'b00, 2'd0, 2'd0, 8'hF0));
    wr(1, ins(2'b00, 2'd1, 2'd0, 8'h20));
    wr(2, ins(2'b01, 2'd0, 2'd1, 8'h00));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_start"}, start, 0);
    check({pfx, "_cc"}, cc, 0);
    check({pfx, "_pc"}, pc, 0);
    check({pfx, "_result"}, result, 0);
    check({pfx, "_zf"}, zero_flag, 0);
    check({pfx, "_cf"}, carry_flag, 0);
    check({pfx, "_done"}, done, 0);
  endtask

  initial begin
    bit seen;
    n_vec = 0; n_err = 0; n_done = 0; ret_pend = 1'b0;
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_last = '0;
    m_zf = 1'b0; m_cf = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // LDI only
    wr(0, ins(2'b00, 2'd1, 2'd0, 8'h05));
    run_chk(0);

    // ADD with carry
    load_add_prog();
    run_chk(2);

    // SUB to zero, then AND
    wr(0, ins(2'b00, 2'd2, 2'd0, 8'h33));
    wr(1, ins(2'b00, 2'd3, 2'd0, 8'h33));
    wr(2, ins(2'b10, 2'd2, 2'd3, 8'h00));
    wr(3, ins(2'b11, 2'd2, 2'd3, 8'h00));
    run_chk(3);

    // Store write and run request while busy must both be ignored
    load_add_prog();
    fork
      run_chk(2);
      begin
        repeat (4) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = ins(2'b00, 2'd0, 2'd0, 8'h00);
        @(negedge clk);
        prog_we = 1'b0; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
      end
    join
    run_chk(2);

    // PC wrap: full store of LDIs, two back-to-back runs
    for (int i = 0; i < 16; i++) wr(i, ins(2'b00, 2'(i), 2'd0, 8'(i * 7 + 1)));
    run_chk(15);
    run_chk(15);

    // Async reset during ALU state
    load_add_prog();
    prog_last = 4'd2;
    push_exp(2);
    pulse_run();
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cs == S_ALU) begin seen = 1'b1; break; end
    end
    if (!seen) check("alu_wait_timeout", 0, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midalu_rst");
    m_zf = 1'b0; m_cf = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(0, ins(2'b01, 2'd0, 2'd1, 8'h00));
    wr(1, ins(2'b10, 2'd2, 2'd3, 8'h00));
    run_chk(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
